// File: rtl/ifu_fetch_if.sv
// Instruction-memory read channel (AR + R) between the fetch unit and imem.
interface ifu_fetch_if;
   logic        arvalid;
   logic [31:0] araddr;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;

   modport master (output arvalid, araddr, rready,
                   input  arready, rvalid, rdata, rresp);
   modport slave  (input  arvalid, araddr, rready,
                   output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/ifu_fetch.sv
// Fetch stage: one non-pipelined instruction read per retire handshake.
//
// state  | meaning
// S_REQ  | drive read address for pc until accepted (or flag misaligned pc)
// S_WAIT | await read data, bounded by the response timer
// S_HOLD | instruction valid for the decoder; wait for pc_update
// S_ERR  | fetch fault recorded; terminal until reset
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [7:0]  MAX_WAIT = 8'd255,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   ifu_fetch_if.master   imem,
   input  logic          pc_update,
   input  logic [31:0]   dnpc,
   output logic [31:0]   pc,
   output logic [31:0]   instruction,
   output logic          IFU_done,
   output logic          fetch_err,
   output logic [1:0]    err_cause
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  cause_q, cause_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        arvalid, rready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      done_d     = 1'b0;
      err_d      = err_q;
      cause_d    = cause_q;
      wait_cnt_d = wait_cnt_q;
      arvalid    = 1'b0;
      rready     = 1'b0;
      case (state_q)
         S_REQ: begin
            if (pc_q[1:0] != 2'b00) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               cause_d = 2'd1;
            end else begin
               arvalid = 1'b1;
               if (imem.arready) begin
                  state_d    = S_WAIT;
                  // down-counter: reaching zero marks the MAX_WAIT-th wait cycle
                  wait_cnt_d = MAX_WAIT - 8'd1;
               end
            end
         end
         S_WAIT: begin
            rready = 1'b1;
            if (imem.rvalid) begin
               if (imem.rresp == 2'b00) begin
                  instr_d = imem.rdata;
                  done_d  = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  cause_d = 2'd2;
               end
            end else if (wait_cnt_q == 8'd0) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               cause_d = 2'd3;
            end else begin
               wait_cnt_d = wait_cnt_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (pc_update) begin
               pc_d    = dnpc;
               state_d = S_REQ;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INST;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cause_q    <= 2'd0;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cause_q    <= cause_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign imem.arvalid = arvalid;
   assign imem.araddr  = pc_q;
   assign imem.rready  = rready;

   assign pc          = pc_q;
   assign instruction = instr_q;
   assign IFU_done    = done_q;
   assign fetch_err   = err_q;
   assign err_cause   = cause_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table vectors, hand-written corner sequences and random
// transactions checked against a per-transaction outcome model.
module tb_ifu_fetch;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int          MAX_WAIT = 255;
   localparam int          MAX_CYC  = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_update = 1'b0;
   logic [31:0] dnpc = '0;
   logic [31:0] pc, instruction;
   logic        ifu_done, fetch_err;
   logic [1:0]  err_cause;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   ifu_fetch_if imem ();

   ifu_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem),
      .pc_update   (pc_update),
      .dnpc        (dnpc),
      .pc          (pc),
      .instruction (instruction),
      .IFU_done    (ifu_done),
      .fetch_err   (fetch_err),
      .err_cause   (err_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          a_dly;
      int          r_dly;
      logic [1:0]  resp;
      logic [31:0] data;
      int          pu_mode;
      logic [31:0] pu_dnpc;
      logic [31:0] npc;
      int          exp_arv;
      int          exp_done;
      logic [1:0]  exp_cause;
   } vec_t;

   vec_t vecs[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      imem.arready = 1'b0;
      imem.rvalid  = 1'b0;
      imem.rresp   = 2'b00;
      imem.rdata   = '0;
      pc_update    = 1'b0;
      dnpc         = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("reset_pc", pc, RESET_PC);
      chk("reset_instr", instruction, NOP_INST);
      chk("reset_done", 32'(ifu_done), 32'd0);
      chk("reset_err", 32'(fetch_err), 32'd0);
      chk("reset_cause", 32'(err_cause), 32'd0);
      rst = 1'b0;
      exp_pc    = RESET_PC;
      exp_instr = NOP_INST;
   endtask

   // Acts as the memory for one fetch; pu_mode 1 pulses pc_update with pu_dnpc
   // on the first wait cycle, pu_mode 2 injects random pc_update/rvalid noise
   // where the DUT must ignore it.
   task automatic mem_txn(input int a_dly, input int r_dly, input logic [1:0] resp,
                          input logic [31:0] data, input int pu_mode, input logic [31:0] pu_dnpc,
                          output int n_arv, output int n_wait, output int done_cnt,
                          output int done_at, output bit addr_ok, output bit finished);
      int tail;
      n_arv = 0; n_wait = 0; done_cnt = 0; done_at = -1;
      addr_ok = 1'b1; finished = 1'b0; tail = -1;
      for (int c = 0; c < MAX_CYC; c++) begin
         imem.arready = 1'b0;
         imem.rvalid  = 1'b0;
         imem.rresp   = 2'b00;
         imem.rdata   = $urandom;
         pc_update    = 1'b0;
         dnpc         = $urandom;
         if (imem.arvalid) begin
            if (imem.araddr !== pc) addr_ok = 1'b0;
            imem.arready = (n_arv == a_dly);
            n_arv++;
            if (pu_mode == 2) pc_update = 1'($urandom_range(0, 1));
         end else if (imem.rready) begin
            if (n_wait == r_dly) begin
               imem.rvalid = 1'b1;
               imem.rresp  = resp;
               imem.rdata  = data;
            end
            if (pu_mode == 1 && n_wait == 0) begin
               pc_update = 1'b1;
               dnpc      = pu_dnpc;
            end else if (pu_mode == 2) begin
               pc_update = 1'($urandom_range(0, 1));
            end
            n_wait++;
         end else if (pu_mode == 2) begin
            imem.rvalid = 1'($urandom_range(0, 1));
         end
         if (ifu_done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (tail < 0 && (ifu_done || fetch_err)) tail = 3;
         if (tail >= 0) begin
            if (tail == 0) begin
               finished = 1'b1;
               break;
            end
            tail--;
         end
         @(negedge clk);
      end
      clear_inputs();
   endtask

   // Outcome of a whole fetch derived from the current pc and the memory timing.
   task automatic fetch_and_check(input int a_dly, input int r_dly, input logic [1:0] resp,
                                  input logic [31:0] data, input int pu_mode,
                                  input logic [31:0] pu_dnpc, output bit errd,
                                  output int n_arv, output int done_cnt,
                                  output int done_at, output logic [1:0] cause);
      int n_wait, e_arv, e_wait, e_done;
      bit addr_ok, finished;
      logic [1:0] e_cause;
      mem_txn(a_dly, r_dly, resp, data, pu_mode, pu_dnpc,
              n_arv, n_wait, done_cnt, done_at, addr_ok, finished);
      if (exp_pc[1:0] != 2'b00) begin
         e_arv = 0; e_wait = 0; e_done = 0; e_cause = 2'd1;
      end else begin
         e_arv = a_dly + 1;
         if (r_dly < MAX_WAIT) begin
            e_wait = r_dly + 1;
            if (resp == 2'b00) begin
               e_done = 1; e_cause = 2'd0; exp_instr = data;
            end else begin
               e_done = 0; e_cause = 2'd2;
            end
         end else begin
            e_wait = MAX_WAIT; e_done = 0; e_cause = 2'd3;
         end
      end
      chk("txn_finished", 32'(finished), 32'd1);
      chk("txn_ar_cycles", n_arv, e_arv);
      chk("txn_araddr", 32'(addr_ok), 32'd1);
      chk("txn_wait_cycles", n_wait, e_wait);
      chk("txn_done_pulses", done_cnt, e_done);
      chk("txn_fetch_err", 32'(fetch_err), 32'(e_cause != 2'd0));
      chk("txn_err_cause", 32'(err_cause), 32'(e_cause));
      chk("txn_instruction", instruction, exp_instr);
      chk("txn_pc", pc, exp_pc);
      errd  = (e_cause != 2'd0);
      cause = err_cause;
   endtask

   task automatic advance(input logic [31:0] npc);
      pc_update = 1'b1;
      dnpc      = npc;
      @(negedge clk);
      pc_update = 1'b0;
      chk("advance_pc", pc, npc);
      exp_pc = npc;
   endtask

   initial begin
      bit errd;
      int n_arv, done_cnt, done_at;
      logic [1:0] cause;
      logic [31:0] npc;

      vecs[0] = '{0, 0, 2'b00, 32'h0010_0093, 0, 32'h0,      32'h8000_0004, 1, 1, 2'd0};
      vecs[1] = '{3, 4, 2'b00, 32'h0020_0113, 1, 32'h1234,   32'h8000_0002, 4, 1, 2'd0};
      vecs[2] = '{0, 0, 2'b00, 32'h0030_0193, 0, 32'h0,      32'h8000_0008, 0, 0, 2'd1};

      clear_inputs();
      @(negedge clk);
      do_reset();

      foreach (vecs[i]) begin
         fetch_and_check(vecs[i].a_dly, vecs[i].r_dly, vecs[i].resp, vecs[i].data,
                         vecs[i].pu_mode, vecs[i].pu_dnpc, errd, n_arv, done_cnt, done_at, cause);
         chk($sformatf("vec%0d_ar_cycles", i), n_arv, vecs[i].exp_arv);
         chk($sformatf("vec%0d_done", i), done_cnt, vecs[i].exp_done);
         chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(vecs[i].exp_cause));
         if (i == 0) chk("first_done_latency", done_at, 2);
         if (!errd) advance(vecs[i].npc);
      end

      // bus error keeps the previously fetched word
      do_reset();
      fetch_and_check(0, 0, 2'b00, 32'h0040_0213, 0, 0, errd, n_arv, done_cnt, done_at, cause);
      advance(32'h8000_0004);
      fetch_and_check(1, 1, 2'b10, 32'hFFFF_FFFF, 0, 0, errd, n_arv, done_cnt, done_at, cause);
      chk("buserr_instr_kept", instruction, 32'h0040_0213);

      // no response at all
      do_reset();
      fetch_and_check(0, 1000, 2'b00, 32'h0, 0, 0, errd, n_arv, done_cnt, done_at, cause);
      chk("timeout_cause", 32'(err_cause), 32'd3);

      // response on the timeout cycle wins
      do_reset();
      fetch_and_check(2, MAX_WAIT - 1, 2'b00, 32'h0050_0293, 0, 0, errd, n_arv, done_cnt, done_at, cause);
      chk("late_resp_no_err", 32'(fetch_err), 32'd0);

      // pc_update coincident with IFU_done
      do_reset();
      imem.arready = 1'b1;
      @(negedge clk);
      imem.arready = 1'b0;
      imem.rvalid  = 1'b1;
      imem.rdata   = 32'h0060_0313;
      @(negedge clk);
      imem.rvalid = 1'b0;
      chk("coinc_done", 32'(ifu_done), 32'd1);
      chk("coinc_instr", instruction, 32'h0060_0313);
      pc_update = 1'b1;
      dnpc      = 32'h8000_0010;
      @(negedge clk);
      pc_update = 1'b0;
      chk("coinc_done_drop", 32'(ifu_done), 32'd0);
      chk("coinc_pc", pc, 32'h8000_0010);
      chk("coinc_arvalid", 32'(imem.arvalid), 32'd1);
      chk("coinc_araddr", imem.araddr, 32'h8000_0010);
      exp_pc    = 32'h8000_0010;
      exp_instr = 32'h0060_0313;
      fetch_and_check(0, 1, 2'b00, 32'h0070_0393, 0, 0, errd, n_arv, done_cnt, done_at, cause);

      // reset in the middle of a read, then a stale response
      do_reset();
      imem.arready = 1'b1;
      @(negedge clk);
      imem.arready = 1'b0;
      chk("midrst_in_wait", 32'(imem.rready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      imem.rvalid = 1'b1;
      imem.rdata  = 32'hDEAD_BEEF;
      chk("midrst_pc", pc, RESET_PC);
      chk("midrst_instr", instruction, NOP_INST);
      chk("midrst_done", 32'(ifu_done), 32'd0);
      chk("midrst_rready", 32'(imem.rready), 32'd0);
      chk("midrst_arvalid", 32'(imem.arvalid), 32'd1);
      chk("midrst_araddr", imem.araddr, RESET_PC);
      @(negedge clk);
      imem.rvalid = 1'b0;
      chk("midrst_stale_done", 32'(ifu_done), 32'd0);
      chk("midrst_stale_instr", instruction, NOP_INST);
      exp_pc    = RESET_PC;
      exp_instr = NOP_INST;
      fetch_and_check(0, 0, 2'b00, 32'h0080_0413, 0, 0, errd, n_arv, done_cnt, done_at, cause);

      // random traffic
      do_reset();
      for (int k = 0; k < 60; k++) begin
         logic [1:0] resp;
         resp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         fetch_and_check($urandom_range(0, 4), $urandom_range(0, 6), resp, $urandom,
                         2, 0, errd, n_arv, done_cnt, done_at, cause);
         if (errd) begin
            do_reset();
         end else begin
            npc = $urandom;
            if ($urandom_range(0, 9) != 0) npc[1:0] = 2'b00;
            advance(npc);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
